// File: rtl/int_priority_controller.sv
// Pending-bit interrupt collector with fixed priority (index 0 highest)
// and a request/ack/return handshake to the core.
module int_priority_controller #(
  parameter int NUM_SOURCES  = 4,
  parameter int VECTOR_WIDTH = $clog2(NUM_SOURCES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SOURCES-1:0]  irq_pulse,
  input  logic [NUM_SOURCES-1:0]  irq_enable,
  input  logic                    global_int_enable,
  input  logic                    int_ack,
  input  logic                    int_return,
  input  logic [NUM_SOURCES-1:0]  overrun_clr,
  output logic                    int_req,
  output logic [VECTOR_WIDTH-1:0] int_vector,
  output logic                    int_active,
  output logic [NUM_SOURCES-1:0]  pending,
  output logic [NUM_SOURCES-1:0]  overrun
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SOURCES-1:0]  cand;
  logic [NUM_SOURCES-1:0]  ack_clr;
  logic [NUM_SOURCES-1:0]  pending_d;
  logic [NUM_SOURCES-1:0]  overrun_d;
  logic [VECTOR_WIDTH-1:0] winner;
  logic [VECTOR_WIDTH-1:0] vector_d;
  logic                    ack_fire;
  logic                    load_vec;

  assign cand = global_int_enable ? (pending & irq_enable) : '0;

  always_comb begin
    winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (cand[i]) winner = VECTOR_WIDTH'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_fire = 1'b0;
    load_vec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cand != '0) begin
          load_vec = 1'b1;
          state_d  = REQUEST;
        end
      end
      REQUEST: begin
        if (int_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (int_return) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_clr  = ack_fire ? (NUM_SOURCES'(1) << int_vector) : '0;
  assign vector_d = load_vec ? winner : int_vector;

  // A new pulse always re-arms the bit, even against the ack clear
  assign pending_d = (pending & ~ack_clr) | irq_pulse;

  // An event is lost only if the bit stays pending; set beats clear
  assign overrun_d = (overrun & ~overrun_clr)
                   | (irq_pulse & pending & ~ack_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      int_req    <= 1'b0;
      int_active <= 1'b0;
      int_vector <= '0;
      pending    <= '0;
      overrun    <= '0;
    end else begin
      state_q    <= state_d;
      int_req    <= (state_d == REQUEST);
      int_active <= (state_d == SERVICE);
      int_vector <= vector_d;
      pending    <= pending_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_int_priority_controller.sv
// Directed table-driven bench for int_priority_controller.
// Rows are applied one per clock; outputs are compared 1 time unit after the edge.
module tb_int_priority_controller;

  logic       clk;
  logic       rst;
  logic [3:0] irq_pulse;
  logic [3:0] irq_enable;
  logic       global_int_enable;
  logic       int_ack;
  logic       int_return;
  logic [3:0] overrun_clr;
  logic       int_req;
  logic [1:0] int_vector;
  logic       int_active;
  logic [3:0] pending;
  logic [3:0] overrun;

  int passed;
  int total;

  int_priority_controller dut (
    .clk               (clk),
    .rst               (rst),
    .irq_pulse         (irq_pulse),
    .irq_enable        (irq_enable),
    .global_int_enable (global_int_enable),
    .int_ack           (int_ack),
    .int_return        (int_return),
    .overrun_clr       (overrun_clr),
    .int_req           (int_req),
    .int_vector        (int_vector),
    .int_active        (int_active),
    .pending           (pending),
    .overrun           (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pulse;
    logic [3:0] en;
    logic       gie;
    logic       ack;
    logic       ret;
    logic [3:0] oclr;
    logic       req;
    logic [1:0] vec;
    logic       act;
    logic [3:0] pnd;
    logic [3:0] ovr;
  } vec_t;

  vec_t tab[$];

  task automatic row(input logic [3:0] pulse, input logic [3:0] en,
                     input logic gie, input logic ack, input logic ret,
                     input logic [3:0] oclr, input logic req,
                     input logic [1:0] vec, input logic act,
                     input logic [3:0] pnd, input logic [3:0] ovr);
    vec_t v;
    v.pulse = pulse; v.en = en; v.gie = gie; v.ack = ack;
    v.ret = ret; v.oclr = oclr; v.req = req; v.vec = vec;
    v.act = act; v.pnd = pnd; v.ovr = ovr;
    tab.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] pulse, input logic [3:0] en,
                       input logic gie, input logic ack, input logic ret,
                       input logic [3:0] oclr);
    irq_pulse = pulse; irq_enable = en; global_int_enable = gie;
    int_ack = ack; int_return = ret; overrun_clr = oclr;
  endtask

  task automatic chk_all(input string tag, input logic req,
                         input logic [1:0] vec, input logic act,
                         input logic [3:0] pnd, input logic [3:0] ovr);
    chk({tag, " int_req"}, int'(int_req), int'(req));
    chk({tag, " int_vector"}, int'(int_vector), int'(vec));
    chk({tag, " int_active"}, int'(int_active), int'(act));
    chk({tag, " pending"}, int'(pending), int'(pnd));
    chk({tag, " overrun"}, int'(overrun), int'(ovr));
  endtask

  initial begin
    int bad;
    passed = 0;
    total  = 0;

    // single pulse
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'b0000);
    row(4'b0100, 4'hF, 1, 0, 0, 4'h0, 0, 0, 0, 4'b0100, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 1, 2, 0, 4'b0100, 4'b0000);
    row(4'b0000, 4'hF, 1, 1, 0, 4'h0, 0, 2, 1, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 0, 2, 1, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 1, 4'h0, 0, 2, 0, 4'b0000, 4'b0000);
    // priority: 1 then 3, with an idle cycle between
    row(4'b1010, 4'hF, 1, 0, 0, 4'h0, 0, 2, 0, 4'b1010, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 1, 1, 0, 4'b1010, 4'b0000);
    row(4'b0000, 4'hF, 1, 1, 0, 4'h0, 0, 1, 1, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 1, 4'h0, 0, 1, 0, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 1, 3, 0, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 1, 1, 0, 4'h0, 0, 3, 1, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 1, 4'h0, 0, 3, 0, 4'b0000, 4'b0000);
    // overrun, clear, and set-wins during ack
    row(4'b1000, 4'hF, 1, 0, 0, 4'h0, 0, 3, 0, 4'b1000, 4'b0000);
    row(4'b1000, 4'hF, 1, 0, 0, 4'h0, 1, 3, 0, 4'b1000, 4'b1000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h8, 1, 3, 0, 4'b1000, 4'b0000);
    row(4'b1000, 4'hF, 1, 1, 0, 4'h0, 0, 3, 1, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 1, 4'h0, 0, 3, 0, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 1, 0, 0, 4'h0, 1, 3, 0, 4'b1000, 4'b0000);
    // held request and stray handshakes
    row(4'b0000, 4'hF, 0, 0, 0, 4'h0, 1, 3, 0, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 0, 0, 1, 4'h0, 1, 3, 0, 4'b1000, 4'b0000);
    row(4'b0000, 4'hF, 0, 1, 0, 4'h0, 0, 3, 1, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 0, 1, 0, 4'h0, 0, 3, 1, 4'b0000, 4'b0000);
    row(4'b0000, 4'hF, 0, 0, 1, 4'h0, 0, 3, 0, 4'b0000, 4'b0000);

    rst = 1'b1;
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    step();
    chk_all("reset", 0, 0, 0, 4'h0, 4'h0);
    rst = 1'b0;

    foreach (tab[i]) begin
      drive(tab[i].pulse, tab[i].en, tab[i].gie,
            tab[i].ack, tab[i].ret, tab[i].oclr);
      step();
      chk_all($sformatf("row%0d", i), tab[i].req, tab[i].vec,
              tab[i].act, tab[i].pnd, tab[i].ovr);
    end

    // masked source stays pending without a request
    drive(4'b0001, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    drive(4'b0000, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("mask pending", int'(pending), 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (int_req !== 1'b0) bad++;
    end
    chk("mask no req cycles", bad, 0);
    irq_enable = 4'b0001;
    step();
    chk("unmask req", int'(int_req), 1);
    chk("unmask vec", int'(int_vector), 0);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("mask svc active", int'(int_active), 1);
    irq_pulse = 4'b1001;
    step();
    irq_pulse = 4'b0000;
    chk("pre-rst pending", int'(pending), 9);
    chk("pre-rst active", int'(int_active), 1);

    // async reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk_all("async rst", 0, 0, 0, 4'h0, 4'h0);
    step();
    rst = 1'b0;
    irq_enable = 4'hF;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (int_req !== 1'b0 || pending !== 4'h0) bad++;
    end
    chk("post-rst quiet", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/int_priority_controller.md
# int_priority_controller

Collects single-cycle interrupt pulses from peripheral handlers (timer interrupt handlers, UART, external pins) and holds each one as a pending bit. It selects the highest-priority enabled source and presents it to the CPU core through a request/acknowledge/return handshake. It sits directly downstream of every timer interrupt handler, consuming its `interrupt_request` pulse, and directly upstream of the core's interrupt entry logic.

## Interface
- `NUM_SOURCES`, 4 — number of interrupt sources; index 0 has the highest priority.
- `VECTOR_WIDTH`, `$clog2(NUM_SOURCES)` — width of the vector/ID outputs.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_pulse`  in  NUM_SOURCES  per-source event; one-cycle-high pulses; a level held N cycles counts as N events.
- `irq_enable`  in  NUM_SOURCES  per-source dispatch mask.
- `global_int_enable`  in  1  master dispatch enable.
- `int_ack`  in  1  core accepts the presented vector.
- `int_return`  in  1  core finished the service routine (RETI).
- `overrun_clr`  in  NUM_SOURCES  clears the matching overrun bits.
- `int_req`  out  1  request to core.
- `int_vector`  out  VECTOR_WIDTH  ID of the requested or in-service source.
- `int_active`  out  1  a service routine is in progress.
- `pending`  out  NUM_SOURCES  pending bits.
- `overrun`  out  NUM_SOURCES  sticky lost-event flags.

## Operation
- **Pending capture.** `irq_pulse[i]` sets `pending[i]` on the next edge. Capture is independent of `irq_enable` and `global_int_enable`, so masked events stay pending.
- **Overrun.** When `irq_pulse[i]` is high while `pending[i]` is already 1, `overrun[i]` is set. Set wins over a simultaneous `overrun_clr[i]`.
- **Candidates.** `cand = pending & irq_enable`, gated by `global_int_enable`. The winner is the lowest-index set bit.
- **FSM states: IDLE, REQUEST, SERVICE.**
  - IDLE: if `cand != 0`, register the winner into `int_vector` and go to REQUEST.
  - REQUEST: `int_req` = 1 and `int_vector` is frozen. The request is not withdrawn, even if the source becomes masked or `global_int_enable` drops. On `int_ack`, clear `pending[int_vector]` and go to SERVICE.
  - SERVICE: `int_active` = 1 and `int_vector` holds the in-service ID. There is no nesting; new events only accumulate as pending. On `int_return`, go to IDLE.
- **Ignored handshake inputs.** `int_ack` outside REQUEST is ignored. `int_return` outside SERVICE is ignored.
- **Simultaneous pulse and ack clear.** When `irq_pulse[v]` arrives in the same cycle that ack clears `pending[v]`, the set wins: the bit stays 1 and no overrun is flagged.
- **Reset.** Asynchronous `rst` in any state returns the FSM to IDLE and zeroes all outputs and registers: `int_req`=0, `int_vector`=0, `int_active`=0, `pending`=0, `overrun`=0. An in-flight request or service is discarded.

## Timing
- **Pulse to request.** A pulse sampled at edge N sets pending at N. IDLE evaluates at N+1, and `int_req` is high after edge N+1. Minimum latency is 2 cycles from the pulse cycle.
- **Ack.** `int_ack` sampled at edge M drops `int_req`, clears pending and raises `int_active` after edge M. The ack may be asserted in the first REQUEST cycle.
- **Return.** `int_return` sampled at edge R drops `int_active` after R. The next request can appear after edge R+1 at the earliest, so there is at least one IDLE cycle between services.
- **Output registering.** All outputs are registers; there are no combinational paths from inputs to outputs.

## Test plan
- **Single pulse.** Reset, `irq_enable`=4'b1111, global enable=1. Pulse `irq_pulse`=4'b0100 for one cycle at cycle 5.
  - `pending`=4'b0100 after cycle 5.
  - `int_req`=1 with `int_vector`=2 two cycles after the pulse.
  - `int_ack` one cycle later gives `int_req`=0, `int_active`=1, `pending`=0.
  - `int_return` gives `int_active`=0.
- **Priority.** Pulse 4'b1010 in one cycle.
  - Vector 1 is served first.
  - After its return, an IDLE cycle, then vector 3 is requested.
- **Masking.** `irq_enable`=4'b0000, pulse source 0.
  - `pending[0]`=1 and `int_req` stays 0 for 20 cycles.
  - Setting `irq_enable[0]`=1 gives `int_req`=1 one cycle later.
- **Overrun and set-wins.**
  - Pulse source 3 twice without ack: `overrun[3]`=1. Assert `overrun_clr[3]`: `overrun[3]`=0.
  - During the ack cycle of vector 3, pulse source 3 again: `pending[3]` stays 1 and `overrun[3]` stays 0.
- **Held request and stray handshake.**
  - In REQUEST, drop `global_int_enable`: `int_req` stays 1 with `int_vector` unchanged.
  - Assert `int_return` in REQUEST and `int_ack` in SERVICE: no state change.
- **Async reset mid-service.** Assert `rst` between edges while in SERVICE with `pending`=4'b1001.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After `rst` release, no request appears without new pulses.
